// File: rtl/int_regfile_sb_if.sv
// rtl/int_regfile_sb_if.sv - decode/writeback bus of the register file with scoreboard
interface int_regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            ready;
  logic            wen;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_wdata;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_rdata;
  logic [XLEN-1:0] rs2_rdata;
  logic            issue_en;
  logic [AW-1:0]   issue_addr;
  logic            rs1_busy;
  logic            rs2_busy;

  modport master (
    input  ready, rs1_rdata, rs2_rdata, rs1_busy, rs2_busy,
    output wen, rd_addr, rd_wdata, rs1_addr, rs2_addr, issue_en, issue_addr
  );

  modport slave (
    output ready, rs1_rdata, rs2_rdata, rs1_busy, rs2_busy,
    input  wen, rd_addr, rd_wdata, rs1_addr, rs2_addr, issue_en, issue_addr
  );
endinterface

// File: rtl/int_regfile_sb.sv
// rtl/int_regfile_sb.sv - register file with clear sequencer and scoreboard; REGFILE_BYPASS_EN adds write-to-read forwarding
module int_regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  int_regfile_sb_if.slave rf
);
  localparam int            AW       = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_idx, clr_idx_nxt;
  logic            ready;

  // x0 has no storage; entries 1..NREGS-1 only
  logic [XLEN-1:0] mem [1:NREGS-1];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  logic [NREGS-1:0] busy, busy_nxt;
  logic             wr_fire, iss_fire;

  logic [AW-1:0]   rs_addr [2];
  logic [XLEN-1:0] rs_data [2];
  logic            rs_busy [2];

  assign ready    = (state == RUN);
  assign wr_fire  = ready && rf.wen && (rf.rd_addr != '0);
  assign iss_fire = ready && rf.issue_en && (rf.issue_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_idx <= AW'(1);
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // The clear sequencer owns the write port until the last entry is zeroed
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    mem_we      = 1'b0;
    mem_waddr   = rf.rd_addr;
    mem_wdata   = rf.rd_wdata;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx;
        mem_wdata = '0;
        if (clr_idx == LAST_IDX) begin
          state_nxt = RUN;
        end else begin
          clr_idx_nxt = clr_idx + AW'(1);
        end
      end
      RUN: begin
        mem_we = wr_fire;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Set after clear so a new producer issued on a retiring register keeps it busy
  always_comb begin
    busy_nxt = busy;
    if (wr_fire) begin
      busy_nxt[rf.rd_addr] = 1'b0;
    end
    if (iss_fire) begin
      busy_nxt[rf.issue_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign rs_addr[0] = rf.rs1_addr;
  assign rs_addr[1] = rf.rs2_addr;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rs_data[p] = '0;
      rs_busy[p] = 1'b0;
      if (ready && (rs_addr[p] != '0)) begin
        rs_data[p] = mem[rs_addr[p]];
        rs_busy[p] = busy[rs_addr[p]];
`ifdef REGFILE_BYPASS_EN
        if (wr_fire && (rs_addr[p] == rf.rd_addr)) begin
          rs_data[p] = rf.rd_wdata;
          if (!(iss_fire && (rf.issue_addr == rs_addr[p]))) begin
            rs_busy[p] = 1'b0;
          end
        end
`endif
      end
    end
  end

  assign rf.ready     = ready;
  assign rf.rs1_rdata = rs_data[0];
  assign rf.rs2_rdata = rs_data[1];
  assign rf.rs1_busy  = rs_busy[0];
  assign rf.rs2_busy  = rs_busy[1];
endmodule

// File: doc/int_regfile_sb.md
Name: int_regfile_sb

Overview:
- Parametrised successor to the integer register file: XLEN-wide, NREGS-entry architectural register file.
- Two combinational read ports, one synchronous write port; x0 is hardwired to zero.
- Adds a post-reset clear sequencer and a per-register pending-write scoreboard. The decode stage uses the scoreboard for hazard stalls.
- Sits between decode (reads, issue) and writeback (write).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers including x0. Must be a power of two, ≥ 4.
- AW (localparam), $clog2(NREGS), register address width.

Ports:
- clk  input  1  Clock; all state updates on the rising edge.
- rst_n  input  1  Asynchronous active-low reset.
- ready  output  1  High when the clear sequence is done and the file accepts traffic.
- wen  input  1  Writeback write enable.
- rd_addr  input  AW  Write address.
- rd_wdata  input  XLEN  Write data.
- rs1_addr  input  AW  Read port 1 address.
- rs2_addr  input  AW  Read port 2 address.
- rs1_rdata  output  XLEN  Read port 1 data (combinational).
- rs2_rdata  output  XLEN  Read port 2 data (combinational).
- issue_en  input  1  Marks an instruction issued with a pending write.
- issue_addr  input  AW  Destination of the issued instruction.
- rs1_busy  output  1  rs1_addr has a pending write.
- rs2_busy  output  1  rs2_addr has a pending write.

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is asynchronous assert, synchronous deassert (external synchroniser).
- Storage: NREGS-1 entries for x1..x(NREGS-1). Address 0 has no storage.
- Reset assertion (asynchronous) sets:
  - state=CLEAR, clr_idx=1, ready=0.
  - All scoreboard bits = 0.
- State machine, 2 states:
  - CLEAR: each cycle writes 0 to entry clr_idx, then clr_idx++. In the cycle where clr_idx==NREGS-1, that entry is written and the FSM goes to RUN.
  - Timing: ready rises NREGS-1 cycles after the first rising edge with rst_n=1. Default config: 31 cycles.
  - RUN: normal operation. The FSM stays in RUN until the next reset.
- While ready=0:
  - wen and issue_en are ignored.
  - rs1_rdata/rs2_rdata = 0; rs1_busy/rs2_busy = 0.
- Reset during CLEAR or RUN: immediate return to CLEAR with clr_idx=1. The whole sequence restarts.
- Write (RUN): if wen && rd_addr!=0, entry rd_addr takes rd_wdata at the edge. Writes to x0 are dropped silently.
- Read: rsN_rdata = 0 if rsN_addr==0, else the stored entry. Same-cycle write visibility depends on REGFILE_BYPASS_EN.
- Scoreboard, busy[1..NREGS-1] (RUN only):
  - issue_en && issue_addr!=0 sets busy[issue_addr].
  - wen && rd_addr!=0 clears busy[rd_addr].
  - Same address set and cleared in one cycle: set wins (a new producer is in flight).
  - issue_addr==0 has no effect; busy[0] is constant 0.
  - Clearing a non-busy register is legal and has no effect.
- rsN_busy = ready && rsN_addr!=0 && busy[rsN_addr], subject to the bypass masking below.
- Latency: write becomes visible in storage 1 cycle after the edge. Scoreboard update is visible the cycle after the edge.
- Simultaneous rs1_addr==rs2_addr: both ports return identical data and busy.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If ready && wen && rd_addr!=0 && rsN_addr==rd_addr, then rsN_rdata = rd_wdata in the same cycle.
  - rsN_busy is masked to 0 for that port, unless issue_en targets the same address this cycle, in which case busy remains as stored.
- Undefined: reads return the pre-edge stored value. rsN_busy reflects stored busy bits only, so the reader sees the new value one cycle later.

Test Plan:
- Clear sequence: pulse rst_n low 3 cycles, release -> ready=0 for exactly 31 cycles, then 1. All reads of x1..x31 return 0x00000000.
- x0 hardwire: wen=1, rd_addr=0, rd_wdata=0xDEADBEEF; next cycle read rs1_addr=0 -> 0. issue_en with issue_addr=0 -> rs1_busy=0.
- Write/read and bypass: write x5=0x12345678 with rs1_addr=5 in the same cycle.
  - With REGFILE_BYPASS_EN: rs1_rdata=0x12345678 that cycle.
  - Without: old value (0) that cycle, 0x12345678 the next cycle.
- Scoreboard set/clear collision: issue x7 -> rs2_busy=1 next cycle. Then in one cycle set wen on x7 and issue_en on x7 -> busy stays 1. A later wen on x7 alone -> busy 0.
- Reset mid-operation: write x3=0xA5A5A5A5, set busy x3, assert rst_n mid-cycle.
  - Immediately: ready=0 and rs1_busy=0 (asynchronous).
  - After release and 31 cycles: x3 reads 0 and busy=0.
- Ignored traffic during CLEAR: drive wen x9=0xFFFFFFFF and issue_en x9 during cycle 10 of CLEAR -> after ready, x9=0 and busy[9]=0.
